// File: rtl/regfile_mp_pkg.sv
// ---------------------------------------------------------------------------
// regfile_mp_pkg : shared Y86 register-file constants and index helper
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package regfile_mp_pkg;

  localparam int unsigned Y86_DATA_W = 64;
  localparam int unsigned Y86_NREGS  = 15;
  localparam int unsigned Y86_AW     = 4;
  localparam int unsigned Y86_SP_IDX = 4;
  localparam logic [Y86_AW-1:0] RNONE = 4'hF;

  // An index names a real register only if it is below NREGS and is not the all-ones "none" code.
  function automatic logic idx_ok(input int unsigned idx,
                                  input int unsigned nregs,
                                  input int unsigned aw);
    int unsigned rnone;
    rnone = (32'd1 << aw) - 32'd1;
    return (idx < nregs) && (idx != rnone);
  endfunction

endpackage

`default_nettype wire

// File: rtl/regfile_mp_if.sv
// ---------------------------------------------------------------------------
// regfile_mp_if : read/write/claim bus between the pipeline and the register file
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface regfile_mp_if
  import regfile_mp_pkg::*;
#(
  parameter int unsigned DATA_W = Y86_DATA_W,
  parameter int unsigned AW     = Y86_AW
);

  logic [AW-1:0]     srcA;
  logic [AW-1:0]     srcB;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [DATA_W-1:0] valStk;
  logic [AW-1:0]     dstE;
  logic [AW-1:0]     dstM;
  logic [DATA_W-1:0] E;
  logic [DATA_W-1:0] M;
  logic              claim_en;
  logic [AW-1:0]     claim_e;
  logic [AW-1:0]     claim_m;
  logic              pend_hazard;
  logic [AW-1:0]     pend_cnt;

  modport master (
    output srcA, srcB, dstE, dstM, E, M, claim_en, claim_e, claim_m,
    input  valA, valB, valStk, pend_hazard, pend_cnt
  );

  modport slave (
    input  srcA, srcB, dstE, dstM, E, M, claim_en, claim_e, claim_m,
    output valA, valB, valStk, pend_hazard, pend_cnt
  );

endinterface

`default_nettype wire

// File: rtl/regfile_scoreboard.sv
// ---------------------------------------------------------------------------
// regfile_scoreboard : per-register pending bits, read hazard and pending count
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_scoreboard
  import regfile_mp_pkg::*;
#(
  parameter int unsigned NREGS  = Y86_NREGS,
  parameter int unsigned AW     = Y86_AW,
  parameter bit          BYPASS = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] src_a_i,
  input  logic [AW-1:0] src_b_i,
  input  logic [AW-1:0] dst_e_i,
  input  logic [AW-1:0] dst_m_i,
  input  logic          claim_en_i,
  input  logic [AW-1:0] claim_e_i,
  input  logic [AW-1:0] claim_m_i,
  output logic          pend_hazard_o,
  output logic [AW-1:0] pend_cnt_o
);

  logic [NREGS-1:0] pend_q;
  logic [NREGS-1:0] pend_d;
  logic [AW-1:0]    cnt_q;
  logic [AW-1:0]    cnt_d;
  logic             wb_e_ok;
  logic             wb_m_ok;
  logic             cl_e_ok;
  logic             cl_m_ok;
  logic             haz_a;
  logic             haz_b;

  assign wb_e_ok = idx_ok(32'(dst_e_i), NREGS, AW);
  assign wb_m_ok = idx_ok(32'(dst_m_i), NREGS, AW);
  assign cl_e_ok = idx_ok(32'(claim_e_i), NREGS, AW);
  assign cl_m_ok = idx_ok(32'(claim_m_i), NREGS, AW);

  // Claims are applied after writeback clears so a same-edge claim keeps the bit set.
  always_comb begin
    pend_d = pend_q;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if ((wb_e_ok && dst_e_i == AW'(i)) || (wb_m_ok && dst_m_i == AW'(i)))
        pend_d[i] = 1'b0;
      if (claim_en_i && ((cl_e_ok && claim_e_i == AW'(i)) || (cl_m_ok && claim_m_i == AW'(i))))
        pend_d[i] = 1'b1;
    end
    cnt_d = '0;
    for (int unsigned i = 0; i < NREGS; i++)
      cnt_d = cnt_d + AW'(pend_d[i]);
  end

  always_comb begin
    haz_a = 1'b0;
    haz_b = 1'b0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      if (src_a_i == AW'(i) && pend_q[i]) haz_a = 1'b1;
      if (src_b_i == AW'(i) && pend_q[i]) haz_b = 1'b1;
    end
    if (BYPASS) begin
      if ((wb_e_ok && dst_e_i == src_a_i) || (wb_m_ok && dst_m_i == src_a_i)) haz_a = 1'b0;
      if ((wb_e_ok && dst_e_i == src_b_i) || (wb_m_ok && dst_m_i == src_b_i)) haz_b = 1'b0;
    end
  end

  assign pend_hazard_o = haz_a | haz_b;
  assign pend_cnt_o    = cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      cnt_q  <= '0;
    end else begin
      pend_q <= pend_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/regfile_mp.sv
// ---------------------------------------------------------------------------
// regfile_mp : two-read / two-write Y86 register file with bypass and scoreboard
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int unsigned       DATA_W  = Y86_DATA_W,
  parameter int unsigned       NREGS   = Y86_NREGS,
  parameter int unsigned       AW      = Y86_AW,
  parameter int unsigned       SP_IDX  = Y86_SP_IDX,
  parameter logic [DATA_W-1:0] SP_INIT = '0,
  parameter bit                BYPASS  = 1'b1
) (
  input logic         clk,
  input logic         rst_n,
  regfile_mp_if.slave bus
);

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [AW-1:0]     src    [2];
  logic [DATA_W-1:0] val    [2];
  logic              we_e;
  logic              we_m;

  assign we_e   = idx_ok(32'(bus.dstE), NREGS, AW);
  assign we_m   = idx_ok(32'(bus.dstM), NREGS, AW);
  assign src[0] = bus.srcA;
  assign src[1] = bus.srcB;

  // M is evaluated first so it wins when both ports target the same register.
  always_comb begin
    for (int unsigned i = 0; i < NREGS; i++) begin
      regs_d[i] = regs_q[i];
      if (we_m && bus.dstM == AW'(i))
        regs_d[i] = bus.M;
      else if (we_e && bus.dstE == AW'(i))
        regs_d[i] = bus.E;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= (i == SP_IDX) ? SP_INIT : '0;
    end else begin
      for (int unsigned i = 0; i < NREGS; i++)
        regs_q[i] <= regs_d[i];
    end
  end

  // Out-of-range indices match no entry and read as zero.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      val[p] = '0;
      for (int unsigned i = 0; i < NREGS; i++)
        if (src[p] == AW'(i)) val[p] = regs_q[i];
      if (BYPASS) begin
        if (we_e && bus.dstE == src[p]) val[p] = bus.E;
        if (we_m && bus.dstM == src[p]) val[p] = bus.M;
      end
    end
  end

  assign bus.valA = val[0];
  assign bus.valB = val[1];

  generate
    if (SP_IDX < NREGS) begin : g_stk
      assign bus.valStk = regs_q[SP_IDX];
    end else begin : g_no_stk
      assign bus.valStk = '0;
    end
  endgenerate

  regfile_scoreboard #(
    .NREGS  (NREGS),
    .AW     (AW),
    .BYPASS (BYPASS)
  ) u_scoreboard (
    .clk           (clk),
    .rst_n         (rst_n),
    .src_a_i       (bus.srcA),
    .src_b_i       (bus.srcB),
    .dst_e_i       (bus.dstE),
    .dst_m_i       (bus.dstM),
    .claim_en_i    (bus.claim_en),
    .claim_e_i     (bus.claim_e),
    .claim_m_i     (bus.claim_m),
    .pend_hazard_o (bus.pend_hazard),
    .pend_cnt_o    (bus.pend_cnt)
  );

endmodule

`default_nettype wire

// File: tb/tb_regfile_mp.sv
// ---------------------------------------------------------------------------
// tb_regfile_mp : directed table, reset sequence and random run against a reference model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_regfile_mp;
  import regfile_mp_pkg::*;

  localparam logic [63:0] SPI = 64'h200;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]  srcA, srcB, dstE, dstM, claim_e, claim_m;
  logic [63:0] E, M;
  logic        claim_en;

  regfile_mp_if #(.DATA_W(64), .AW(4)) if0 ();
  regfile_mp_if #(.DATA_W(64), .AW(4)) if1 ();

  assign if0.srcA = srcA;  assign if1.srcA = srcA;
  assign if0.srcB = srcB;  assign if1.srcB = srcB;
  assign if0.dstE = dstE;  assign if1.dstE = dstE;
  assign if0.dstM = dstM;  assign if1.dstM = dstM;
  assign if0.E = E;        assign if1.E = E;
  assign if0.M = M;        assign if1.M = M;
  assign if0.claim_en = claim_en;  assign if1.claim_en = claim_en;
  assign if0.claim_e = claim_e;    assign if1.claim_e = claim_e;
  assign if0.claim_m = claim_m;    assign if1.claim_m = claim_m;

  regfile_mp #(.DATA_W(64), .NREGS(15), .AW(4), .SP_IDX(4), .SP_INIT(SPI), .BYPASS(1'b1))
    u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  regfile_mp #(.DATA_W(64), .NREGS(12), .AW(4), .SP_IDX(4), .SP_INIT(SPI), .BYPASS(1'b0))
    u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  // Reference state: index 0 models the bypassing 15-register file, index 1 the 12-register one.
  logic [63:0] mregs [2][15];
  bit          mpend [2][15];
  int          nregs [2] = '{15, 12};
  bit          mbyp  [2] = '{1'b1, 1'b0};
  int          n_cmp = 0;
  int          n_fail = 0;

  typedef struct {
    logic [3:0]  srcA, srcB, dstE, dstM;
    logic [63:0] E, M;
    logic        cen;
    logic [3:0]  ce, cm;
    logic [63:0] xA1, xB1, xA0, xB0;
    logic        xH1, xH0;
    logic [3:0]  xC1, xC0;
  } vec_t;
  vec_t tv [11];

  function automatic bit ok(int d, logic [3:0] idx);
    return int'(idx) < nregs[d];
  endfunction

  function automatic logic [63:0] m_read(int d, logic [3:0] idx);
    if (!ok(d, idx)) return 64'h0;
    if (mbyp[d] && ok(d, dstM) && dstM == idx) return M;
    if (mbyp[d] && ok(d, dstE) && dstE == idx) return E;
    return mregs[d][idx];
  endfunction

  function automatic bit m_haz(int d, logic [3:0] idx);
    if (!ok(d, idx) || !mpend[d][idx]) return 1'b0;
    if (mbyp[d] && ((ok(d, dstM) && dstM == idx) || (ok(d, dstE) && dstE == idx))) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_cnt(int d);
    int n = 0;
    for (int i = 0; i < 15; i++) n += int'(mpend[d][i]);
    return n;
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 15; i++) begin
        mregs[d][i] = (i == 4) ? SPI : 64'h0;
        mpend[d][i] = 1'b0;
      end
  endtask

  task automatic m_edge();
    for (int d = 0; d < 2; d++) begin
      if (ok(d, dstE)) mregs[d][dstE] = E;
      if (ok(d, dstM)) mregs[d][dstM] = M;
      if (ok(d, dstE)) mpend[d][dstE] = 1'b0;
      if (ok(d, dstM)) mpend[d][dstM] = 1'b0;
      if (claim_en && ok(d, claim_e)) mpend[d][claim_e] = 1'b1;
      if (claim_en && ok(d, claim_m)) mpend[d][claim_m] = 1'b1;
    end
  endtask

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("d0.valA",   if0.valA,   m_read(0, srcA));
    chk("d0.valB",   if0.valB,   m_read(0, srcB));
    chk("d0.valStk", if0.valStk, mregs[0][4]);
    chk("d0.hazard", 64'(if0.pend_hazard), 64'(m_haz(0, srcA) | m_haz(0, srcB)));
    chk("d0.cnt",    64'(if0.pend_cnt), 64'(m_cnt(0)));
    chk("d1.valA",   if1.valA,   m_read(1, srcA));
    chk("d1.valB",   if1.valB,   m_read(1, srcB));
    chk("d1.valStk", if1.valStk, mregs[1][4]);
    chk("d1.hazard", 64'(if1.pend_hazard), 64'(m_haz(1, srcA) | m_haz(1, srcB)));
    chk("d1.cnt",    64'(if1.pend_cnt), 64'(m_cnt(1)));
  endtask

  task automatic idle();
    srcA = 4'hF; srcB = 4'hF; dstE = 4'hF; dstM = 4'hF;
    E = 64'h0; M = 64'h0; claim_en = 1'b0; claim_e = 4'hF; claim_m = 4'hF;
  endtask

  task automatic step();
    @(negedge clk);
    check_model();
    @(posedge clk);
    m_edge();
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by t=200000");
    $fatal(1);
  end

  initial begin
    //        srcA  srcB  dstE  dstM  E       M       cen   ce    cm    xA1      xB1      xA0      xB0      xH1   xH0   xC1   xC0
    tv[0]  = '{4'h0, 4'h4, 4'hF, 4'hF, 64'h0,  64'h0,  1'b0, 4'hF, 4'hF, 64'h0,   64'h200, 64'h0,   64'h200, 1'b0, 1'b0, 4'd0, 4'd0};
    tv[1]  = '{4'h3, 4'hF, 4'h3, 4'h3, 64'h5,  64'h9,  1'b0, 4'hF, 4'hF, 64'h9,   64'h0,   64'h0,   64'h0,   1'b0, 1'b0, 4'd0, 4'd0};
    tv[2]  = '{4'h3, 4'h2, 4'hF, 4'h2, 64'h0,  64'hAA, 1'b0, 4'hF, 4'hF, 64'h9,   64'hAA,  64'h9,   64'h0,   1'b0, 1'b0, 4'd0, 4'd0};
    tv[3]  = '{4'h1, 4'hF, 4'hF, 4'hF, 64'h0,  64'h0,  1'b1, 4'h1, 4'hF, 64'h0,   64'h0,   64'h0,   64'h0,   1'b0, 1'b0, 4'd0, 4'd0};
    tv[4]  = '{4'h1, 4'h2, 4'hF, 4'hF, 64'h0,  64'h0,  1'b0, 4'hF, 4'hF, 64'h0,   64'hAA,  64'h0,   64'hAA,  1'b1, 1'b1, 4'd1, 4'd1};
    tv[5]  = '{4'h1, 4'hF, 4'h1, 4'hF, 64'h11, 64'h0,  1'b0, 4'hF, 4'hF, 64'h11,  64'h0,   64'h0,   64'h0,   1'b0, 1'b1, 4'd1, 4'd1};
    tv[6]  = '{4'h1, 4'h6, 4'hF, 4'h6, 64'h0,  64'h66, 1'b1, 4'hF, 4'h6, 64'h11,  64'h66,  64'h11,  64'h0,   1'b0, 1'b0, 4'd0, 4'd0};
    tv[7]  = '{4'h6, 4'hF, 4'hF, 4'hF, 64'h0,  64'h0,  1'b0, 4'hF, 4'hF, 64'h66,  64'h0,   64'h66,  64'h0,   1'b1, 1'b1, 4'd1, 4'd1};
    tv[8]  = '{4'hF, 4'h6, 4'hF, 4'hF, 64'h0,  64'h0,  1'b0, 4'hF, 4'hF, 64'h0,   64'h66,  64'h0,   64'h66,  1'b1, 1'b1, 4'd1, 4'd1};
    tv[9]  = '{4'hE, 4'h6, 4'hE, 4'hC, 64'hEE, 64'hCC, 1'b1, 4'hC, 4'hF, 64'hEE,  64'h66,  64'h0,   64'h66,  1'b1, 1'b1, 4'd1, 4'd1};
    tv[10] = '{4'hE, 4'hC, 4'hF, 4'hF, 64'h0,  64'h0,  1'b0, 4'hF, 4'hF, 64'hEE,  64'hCC,  64'h0,   64'h0,   1'b1, 1'b0, 4'd2, 4'd1};

    idle();
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.valStk0", if0.valStk, SPI);
    chk("rst.cnt0",    64'(if0.pend_cnt), 64'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int k = 0; k < 11; k++) begin
      srcA = tv[k].srcA; srcB = tv[k].srcB; dstE = tv[k].dstE; dstM = tv[k].dstM;
      E = tv[k].E; M = tv[k].M; claim_en = tv[k].cen; claim_e = tv[k].ce; claim_m = tv[k].cm;
      @(negedge clk);
      chk($sformatf("tv%0d.d0.valA", k), if0.valA, tv[k].xA1);
      chk($sformatf("tv%0d.d0.valB", k), if0.valB, tv[k].xB1);
      chk($sformatf("tv%0d.d1.valA", k), if1.valA, tv[k].xA0);
      chk($sformatf("tv%0d.d1.valB", k), if1.valB, tv[k].xB0);
      chk($sformatf("tv%0d.d0.haz", k), 64'(if0.pend_hazard), 64'(tv[k].xH1));
      chk($sformatf("tv%0d.d1.haz", k), 64'(if1.pend_hazard), 64'(tv[k].xH0));
      chk($sformatf("tv%0d.d0.cnt", k), 64'(if0.pend_cnt), 64'(tv[k].xC1));
      chk($sformatf("tv%0d.d1.cnt", k), 64'(if1.pend_cnt), 64'(tv[k].xC0));
      check_model();
      @(posedge clk);
      m_edge();
      #1;
    end

    // Mid-cycle asynchronous reset with claims and writes in flight.
    idle();
    claim_en = 1'b1; claim_e = 4'h5; dstE = 4'h4; E = 64'h123; srcA = 4'h5; srcB = 4'h4;
    step();
    claim_e = 4'h7; dstE = 4'hF; dstM = 4'h9; M = 64'h999; srcA = 4'h5; srcB = 4'h4;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.d0.valStk", if0.valStk, SPI);
    chk("arst.d1.valStk", if1.valStk, SPI);
    chk("arst.d0.cnt", 64'(if0.pend_cnt), 64'h0);
    chk("arst.d1.cnt", 64'(if1.pend_cnt), 64'h0);
    chk("arst.d0.haz", 64'(if0.pend_hazard), 64'h0);
    chk("arst.d1.haz", 64'(if1.pend_hazard), 64'h0);
    chk("arst.d0.valB", if0.valB, SPI);
    chk("arst.d0.valA", if0.valA, 64'h0);
    srcA = 4'hF;
    #1;
    chk("arst.d0.rnone", if0.valA, 64'h0);
    chk("arst.d1.rnone", if1.valA, 64'h0);
    m_reset();
    @(posedge clk);
    #1;
    dstM = 4'hF; srcA = 4'h9; srcB = 4'h7;
    #1;
    chk("inrst.d0.cnt", 64'(if0.pend_cnt), 64'h0);
    chk("inrst.d0.haz", 64'(if0.pend_hazard), 64'h0);
    chk("inrst.d0.valA", if0.valA, 64'h0);
    chk("inrst.d1.valA", if1.valA, 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    step();

    for (int c = 0; c < 400; c++) begin
      srcA = 4'($urandom_range(0, 15));
      srcB = 4'($urandom_range(0, 15));
      dstE = 4'($urandom_range(0, 15));
      dstM = 4'($urandom_range(0, 15));
      E = {$urandom, $urandom};
      M = {$urandom, $urandom};
      claim_en = 1'($urandom_range(0, 1));
      claim_e = 4'($urandom_range(0, 15));
      claim_m = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) dstM = dstE;
      if ($urandom_range(0, 3) == 0) srcA = dstM;
      if ($urandom_range(0, 3) == 0) srcB = dstE;
      if ($urandom_range(0, 3) == 0) claim_m = dstM;
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 Parameter DATA_W, 64, register data width in bits.
REQ-002 Parameter NREGS, 15, number of architectural registers; legal range 2..15.
REQ-003 Parameter AW, 4, register-index width; index 4'hF (all ones, RNONE) means "no register".
REQ-004 Parameter SP_IDX, 4, stack-pointer register index.
REQ-005 Parameter SP_INIT, 64'h0, stack-pointer value after reset.
REQ-006 Parameter BYPASS, 1, when 1 same-cycle writes are forwarded to read ports.
REQ-007 clk  input  1  system clock; one clock, all state rising-edge.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 srcA, srcB  input  AW  read indices.
REQ-010 valA, valB  output  DATA_W  read data.
REQ-011 valStk  output  DATA_W  current stack-pointer register content, unbypassed.
REQ-012 dstE, dstM  input  AW  write indices for the E and M writeback ports.
REQ-013 E, M  input  DATA_W  write data for the E and M ports.
REQ-014 claim_en  input  1  decode claims destinations claim_e/claim_m this cycle.
REQ-015 claim_e, claim_m  input  AW  destinations being claimed.
REQ-016 pend_hazard  output  1  srcA or srcB has an outstanding claim not yet written back.
REQ-017 pend_cnt  output  AW  number of registers currently pending.

Function
REQ-018 Reads SHALL be combinational; index RNONE or >= NREGS SHALL return 0.
REQ-019 Writes SHALL occur on the rising clk edge; a port whose index is RNONE or >= NREGS SHALL not write.
REQ-020 When dstE == dstM (valid), M SHALL win; E SHALL be discarded.
REQ-021 BYPASS=1: a read whose index matches a valid dstM/dstE in the same cycle SHALL return the write data (M priority); BYPASS=0: the stored value until the edge.
REQ-022 Scoreboard: one pending bit per register; on an edge with claim_en=1, bits for valid claim_e/claim_m SHALL set.
REQ-023 A writeback on dstE or dstM SHALL clear that register's pending bit at the edge.
REQ-024 Simultaneous claim and writeback of the same register SHALL leave the bit set (claim wins).
REQ-025 pend_hazard SHALL be combinational: OR of pending bits of valid srcA/srcB; under BYPASS=1 a same-cycle writeback to that index masks it.
REQ-026 pend_cnt SHALL equal the population count of pending bits, registered, saturating never needed (max NREGS).
REQ-027 valStk SHALL reflect register SP_IDX after the last edge.

Reset
REQ-028 On rst_n low, all registers SHALL be 0 except SP_IDX = SP_INIT, all pending bits cleared, pend_cnt = 0, pend_hazard = 0, asynchronously.
REQ-029 Writes or claims presented while rst_n is low SHALL be ignored; first effect on the first edge after deassertion.

Structure
REQ-030 RNONE, default DATA_W, NREGS and SP_IDX constants SHALL live in the shared Y86 package.
REQ-031 The scoreboard SHALL be a sub-module regfile_scoreboard (pending bits, hazard, count); storage and bypass stay in regfile_mp.

Verification
REQ-032 Reset with SP_INIT=64'h200 -> valStk=64'h200, valA for srcA=0 is 0, pend_cnt=0.
REQ-033 dstE=3,E=5 and dstM=3,M=9 same edge -> after edge srcA=3 reads 9.
REQ-034 BYPASS=1, dstM=2,M=64'hAA, srcB=2 same cycle -> valB=64'hAA before edge; BYPASS=0 -> old value.
REQ-035 claim_en with claim_e=1 -> next cycle srcA=1 gives pend_hazard=1, pend_cnt=1; writeback dstE=1 -> bit clears, pend_cnt=0.
REQ-036 Same edge claim_m=6 and dstM=6 -> pending bit 6 remains set.
REQ-037 Writes pending, rst_n pulsed low mid-cycle -> registers and scoreboard clear immediately; srcA=RNONE reads 0.
